// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: buffers CPU pc/inst/addr snapshots and streams them as three-beat entries
module pc_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter bit DEDUP  = 1'b1,
  parameter int DROP_W = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     cap_en,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              inst_in,
  input  logic [31:0]              addr_in,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_beat,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, S_PC, S_INST, S_ADDR} state_t;
  state_t          r_state;
  logic [95:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [31:0]     r_last_pc;
  logic            r_have_last;
  logic            w_q, w_hs, w_pop, w_wr, w_drop;
  logic [AW:0]     w_level_nxt;
  logic [AW-1:0]   w_rd_nxt;
  logic [31:0]     w_nxt_pc;
  assign w_q         = cap_en && !clr && (!DEDUP || !r_have_last || pc_in != r_last_pc);
  assign w_hs        = out_valid && out_ready;
  assign w_pop       = w_hs && r_state == S_ADDR;
  assign w_wr        = w_q && (level != FULL || w_pop);
  assign w_drop      = w_q && !w_wr;
  assign w_level_nxt = level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
  assign w_rd_nxt    = r_rd_ptr + AW'(1);
  // With one entry left, the next head is the one being written this same cycle
  assign w_nxt_pc    = (level == (AW+1)'(1)) ? pc_in : r_mem[w_rd_nxt][95:64];
  // Entry storage; contents need no reset since level guards every read
  always_ff @(posedge clk_in)
    if (w_wr) r_mem[r_wr_ptr] <= {pc_in, inst_in, addr_in};
  // Pointers, occupancy, overflow accounting and dedup history
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset || clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      r_last_pc   <= '0;
      r_have_last <= 1'b0;
    end else begin
      if (w_q) begin
        r_last_pc   <= pc_in;
        r_have_last <= 1'b1;
      end
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= w_rd_nxt;
      level <= w_level_nxt;
      if (w_drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt + DROP_W'(drop_cnt != '1);
      end
    end
  end
  // Beat sequencer with registered stream outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset || clr) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      out_beat  <= 2'd0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (level != '0) begin
          r_state   <= S_PC;
          out_valid <= 1'b1;
          out_beat  <= 2'd0;
          out_last  <= 1'b0;
          out_data  <= r_mem[r_rd_ptr][95:64];
        end
        S_PC: if (w_hs) begin
          r_state  <= S_INST;
          out_beat <= 2'd1;
          out_data <= r_mem[r_rd_ptr][63:32];
        end
        S_INST: if (w_hs) begin
          r_state  <= S_ADDR;
          out_beat <= 2'd2;
          out_last <= 1'b1;
          out_data <= r_mem[r_rd_ptr][31:0];
        end
        S_ADDR: if (w_hs) begin
          r_state   <= (w_level_nxt != '0) ? S_PC : IDLE;
          out_valid <= w_level_nxt != '0;
          out_beat  <= 2'd0;
          out_last  <= 1'b0;
          out_data  <= (w_level_nxt != '0) ? w_nxt_pc : '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: vector table plus directed sequences, beats checked against a scoreboard queue
module tb_pc_trace_buffer;
  logic        clk_in = 1'b0, reset = 1'b1, clr = 1'b0, cap_en = 1'b0, out_ready = 1'b0;
  logic [31:0] pc_in = '0, inst_in = '0, addr_in = '0;
  logic [31:0] out_data, out_data0;
  logic        out_valid, out_last, overflow, out_valid0, out_last0, overflow0;
  logic [1:0]  out_beat, out_beat0;
  logic [4:0]  level, level0;
  logic [15:0] drop_cnt, drop_cnt0;
  int n_checks = 0, n_errors = 0;

  typedef struct {logic [31:0] data; logic [1:0] beat;} exp_t;
  exp_t sb[$];
  typedef struct {logic [31:0] pc, inst, addr; int hold, exp_d1, exp_d0;} vec_t;
  vec_t vecs[3];

  pc_trace_buffer #(.DEPTH(16), .DEDUP(1'b1), .DROP_W(16)) dut (
    .clk_in(clk_in), .reset(reset), .clr(clr), .cap_en(cap_en), .pc_in(pc_in), .inst_in(inst_in),
    .addr_in(addr_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_beat(out_beat), .out_last(out_last), .level(level), .overflow(overflow), .drop_cnt(drop_cnt));

  pc_trace_buffer #(.DEPTH(16), .DEDUP(1'b0), .DROP_W(16)) dut0 (
    .clk_in(clk_in), .reset(reset), .clr(clr), .cap_en(cap_en), .pc_in(pc_in), .inst_in(inst_in),
    .addr_in(addr_in), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_beat(out_beat0), .out_last(out_last0), .level(level0), .overflow(overflow0), .drop_cnt(drop_cnt0));

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a);
    sb.push_back('{p, 2'd0});
    sb.push_back('{i, 2'd1});
    sb.push_back('{a, 2'd2});
  endtask

  task automatic cap(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a);
    cap_en = 1'b1; pc_in = p; inst_in = i; addr_in = a;
    tick();
    cap_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && budget < 2000) begin
      tick();
      budget++;
    end
    check({name, " drain_left"}, sb.size(), 0);
    tick();
    tick();
    check({name, " idle_valid"}, out_valid, 0);
    check({name, " idle_level"}, level, 0);
  endtask

  // Scoreboard consumer: each accepted beat must match the oldest expected one
  always @(negedge clk_in) begin
    if (!reset && !clr && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_beat", out_data, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_idx", out_beat, e.beat);
        check("beat_last", out_last, e.beat == 2'd2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0040_0004, 32'h8C22_0000, 32'h1001_0004, 5, 1, 5};
    vecs[1] = '{32'h0040_0010, 32'h0022_1820, 32'h0000_0007, 1, 1, 1};
    vecs[2] = '{32'h0040_0020, 32'hAC23_0004, 32'h1001_0008, 3, 1, 3};

    // Reset state
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    tick();

    // 1: single capture latency and beat order
    out_ready = 1'b1;
    push_entry(32'h0040_0000, 32'h3C01_1001, 32'h1001_0000);
    cap(32'h0040_0000, 32'h3C01_1001, 32'h1001_0000);
    check("t1_level_n1", level, 1);
    check("t1_valid_n1", out_valid, 0);
    tick();
    check("t1_valid_n2", out_valid, 1);
    check("t1_pc_n2", out_data, 32'h0040_0000);
    drain("t1");

    // 2: dedup table, DEDUP=1 vs DEDUP=0
    foreach (vecs[v]) begin
      pulse_clr();
      out_ready = 1'b0;
      cap_en = 1'b1; pc_in = vecs[v].pc; inst_in = vecs[v].inst; addr_in = vecs[v].addr;
      repeat (vecs[v].hold) tick();
      cap_en = 1'b0;
      check("t2_level_dedup", level, vecs[v].exp_d1);
      check("t2_level_nodedup", level0, vecs[v].exp_d0);
      check("t2_overflow", overflow, 0);
      push_entry(vecs[v].pc, vecs[v].inst, vecs[v].addr);
      drain("t2");
    end

    // 3: stall on the inst beat
    pulse_clr();
    out_ready = 1'b1;
    push_entry(32'h0040_0000, 32'h3C01_1001, 32'h1001_0000);
    cap(32'h0040_0000, 32'h3C01_1001, 32'h1001_0000);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_data", out_data, 32'h3C01_1001);
      check("t3_hold_beat", out_beat, 1);
      tick();
    end
    drain("t3");

    // 4: overflow with 20 captures into 16 entries
    pulse_clr();
    out_ready = 1'b0;
    cap_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pc_in = 32'h0040_0000 + 32'(4 * k);
      inst_in = 32'hA000_0000 + 32'(k);
      addr_in = 32'h1001_0000 + 32'(16 * k);
      if (k < 16) push_entry(pc_in, inst_in, addr_in);
      tick();
    end
    cap_en = 1'b0;
    check("t4_level", level, 16);
    check("t4_overflow", overflow, 1);
    check("t4_drop", drop_cnt, 4);
    check("t4_head", out_data, 32'h0040_0000);
    drain("t4");

    // 5: full FIFO, capture coincides with addr-beat pop (pointers already wrapped)
    out_ready = 1'b0;
    cap_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pc_in = 32'h0050_0000 + 32'(4 * k);
      inst_in = 32'hB000_0000 + 32'(k);
      addr_in = 32'h2002_0000 + 32'(k);
      push_entry(pc_in, inst_in, addr_in);
      tick();
    end
    cap_en = 1'b0;
    check("t5_full", level, 16);
    out_ready = 1'b1;
    tick();
    tick();
    check("t5_at_addr", out_beat, 2);
    push_entry(32'h0060_0000, 32'hC000_0001, 32'h3003_0000);
    cap(32'h0060_0000, 32'hC000_0001, 32'h3003_0000);
    check("t5_level", level, 16);
    check("t5_drop", drop_cnt, 4);
    drain("t5");

    // 6: clr during inst beat, then async reset mid-cycle
    out_ready = 1'b1;
    push_entry(32'h0070_0000, 32'hD000_0000, 32'h4004_0000);
    cap(32'h0070_0000, 32'hD000_0000, 32'h4004_0000);
    tick();
    tick();
    check("t6_inst_beat", out_beat, 1);
    pulse_clr();
    sb.delete();
    check("t6_clr_valid", out_valid, 0);
    check("t6_clr_level", level, 0);
    check("t6_clr_drop", drop_cnt, 0);
    check("t6_clr_ovf", overflow, 0);
    out_ready = 1'b0;
    cap(32'h0070_0000, 32'hD000_0000, 32'h4004_0000);
    check("t6_dedup_cleared_by_clr", level, 1);
    tick();
    check("t6_pre_rst_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_arst_valid", out_valid, 0);
    check("t6_arst_data", out_data, 0);
    check("t6_arst_level", level, 0);
    #3 reset = 1'b0;
    tick();
    push_entry(32'h0070_0000, 32'hD000_0000, 32'h4004_0000);
    cap(32'h0070_0000, 32'hD000_0000, 32'h4004_0000);
    check("t6_dedup_cleared_by_rst", level, 1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
